// File: rtl/devision_pkg.sv
// Shared types and constants for the repeated-subtraction divider controller.
package devision_pkg;

  // Default operand width. It must match the datapath bus width.
  localparam int unsigned DefaultN = 5;

  // FSM state encoding: 3-bit binary.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLa   = 3'd1,
    StLb   = 3'd2,
    StChk  = 3'd3,
    StSub  = 3'd4,
    StWb   = 3'd5,
    StDone = 3'd6
  } state_e;

  // Control bundle decoded from a state.
  // err is kept out of this bundle because it is held across states.
  typedef struct packed {
    logic lda;
    logic ldb;
    logic clrp;
    logic incp;
    logic selin;
    logic busy;
    logic done;
  } ctrl_t;

  // Largest iteration count that an N-bit counter can represent without wrapping.
  function automatic int unsigned max_iter(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Moore decode of the datapath controls for each state.
  function automatic ctrl_t decode_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    unique case (st)
      StIdle: c = '0;
      StLa: begin
        c.lda  = 1'b1;
        c.busy = 1'b1;
      end
      StLb: begin
        c.ldb  = 1'b1;
        c.clrp = 1'b1;
        c.busy = 1'b1;
      end
      StChk: c.busy = 1'b1;
      StSub: begin
        c.selin = 1'b1;
        c.incp  = 1'b1;
        c.busy  = 1'b1;
      end
      StWb: begin
        c.lda  = 1'b1;
        c.busy = 1'b1;
      end
      StDone: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/devision_controller_if.sv
// Handshake and control bundle between a requester/datapath and the divider controller.
interface devision_controller_if #(
  parameter int unsigned N = devision_pkg::DefaultN
) ();

  logic         start;
  logic [N-1:0] data_in;
  logic         lt;
  logic         gt;
  logic         eq;
  logic         lda;
  logic         ldb;
  logic         clrp;
  logic         incp;
  logic         selin;
  logic         busy;
  logic         done;
  logic         err;

  // Environment side: the requester plus the datapath compare outputs.
  modport master (
    output start, data_in, lt, gt, eq,
    input  lda, ldb, clrp, incp, selin, busy, done, err
  );

  // Controller side.
  modport slave (
    input  start, data_in, lt, gt, eq,
    output lda, ldb, clrp, incp, selin, busy, done, err
  );

endinterface

// File: rtl/devision_controller.sv
// Control FSM for the repeated-subtraction divider. The quotient accumulates in the
// datapath's P register and the remainder is left in A. A zero divisor and an
// exhausted iteration budget both finish with err set.
module devision_controller
  import devision_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned MAX_ITER = max_iter(N)
) (
  input logic                 clk,
  input logic                 rst,
  devision_controller_if.slave bus
);

  localparam logic [N-1:0] MaxIterC = N'(MAX_ITER);

  state_e       state_q, state_d;
  ctrl_t        ctrl_q;
  logic [N-1:0] iter_q;
  logic         zero_q;
  logic         err_q;
  logic         err_set;
  logic         cap_hit;

  // The compare outputs other than lt carry no information the FSM needs.
  logic unused_cmp;
  assign unused_cmp = bus.gt ^ bus.eq;

  assign cap_hit = (iter_q == MaxIterC);

  // Next-state selection and detection of the two error exits.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StLa;
      StLa:   state_d = StLb;
      StLb: begin
        if (zero_q) begin
          state_d = StDone;
          err_set = 1'b1;
        end else begin
          state_d = StChk;
        end
      end
      StChk: begin
        if (bus.lt) begin
          state_d = StDone;
        end else if (cap_hit) begin
          state_d = StDone;
          err_set = 1'b1;
        end else begin
          state_d = StSub;
        end
      end
      StSub:   state_d = StWb;
      StWb:    state_d = StChk;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, registered controls, zero-divisor flag, iteration counter and err.
  // The controls are registered from the next state, so they stay a pure
  // function of the current state without a decode stage on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);

      // The divisor is on data_in only during the load-A cycle.
      if (state_q == StLa) begin
        zero_q <= (bus.data_in == '0);
      end

      if (state_q == StLb) begin
        iter_q <= '0;
      end else if (state_q == StSub && iter_q != '1) begin
        iter_q <= iter_q + 1'b1;
      end

      if (state_q == StIdle && bus.start) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.lda   = ctrl_q.lda;
  assign bus.ldb   = ctrl_q.ldb;
  assign bus.clrp  = ctrl_q.clrp;
  assign bus.incp  = ctrl_q.incp;
  assign bus.selin = ctrl_q.selin;
  assign bus.busy  = ctrl_q.busy;
  assign bus.done  = ctrl_q.done;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_devision_controller.sv
// Bench for the divider controller: a behavioural datapath closes the loop, and a
// scoreboard holds the expected outcome of every accepted request.
module tb_devision_controller;

  localparam int unsigned W    = 5;
  localparam int unsigned CapC = 31;

  logic clk = 1'b0;
  logic rst;
  logic force_lt0;

  always #5 clk = ~clk;

  devision_controller_if #(.N(W)) dif ();

  devision_controller #(.N(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  // Behavioural datapath: bus register, A, B and the quotient register P.
  logic [W-1:0] bus_q, a_q, b_q, p_q;

  always @(posedge clk) begin
    bus_q <= dif.selin ? (a_q - b_q) : dif.data_in;
    if (dif.lda) a_q <= bus_q;
    if (dif.ldb) b_q <= bus_q;
    if (dif.clrp) p_q <= '0;
    else if (dif.incp) p_q <= p_q + 1'b1;
  end

  assign dif.lt = force_lt0 ? 1'b0 : (a_q < b_q);
  assign dif.gt = (a_q > b_q);
  assign dif.eq = (a_q == b_q);

  typedef struct {
    int unsigned cyc;
    int unsigned incps;
    int unsigned q;
    int unsigned r;
    bit          err;
    bit          chk_pa;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ctrl_vec();
    return {24'd0, dif.lda, dif.ldb, dif.clrp, dif.incp, dif.selin, dif.busy, dif.done,
            dif.err};
  endfunction

  // Expected outcome of one request.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input bit nolt);
    exp_t e;
    if (b == 0) begin
      e.cyc = 3; e.incps = 0; e.q = 0; e.r = 0; e.err = 1'b1; e.chk_pa = 1'b0;
    end else if (nolt) begin
      // With lt stuck low the loop only stops at the iteration cap.
      e.cyc = 4 + 3 * CapC; e.incps = CapC; e.q = CapC;
      e.r = (a - CapC * b) & 32'h1f; e.err = 1'b1; e.chk_pa = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.cyc = 4 + 3 * e.q; e.incps = e.q;
      e.err = 1'b0; e.chk_pa = 1'b1;
    end
    return e;
  endfunction

  // Output monitor: times each accepted request and scores it at done.
  int   mon_cyc   = 0;
  int   start_cyc = 0;
  int   incps     = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst) begin
        if (dif.start && !dif.busy) begin
          start_cyc = mon_cyc;
          incps     = 0;
        end
        if (dif.incp) incps++;
        if (dif.done) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_done", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            check_eq("done_cycle", mon_cyc - start_cyc, mon_e.cyc);
            check_eq("err_at_done", dif.err, mon_e.err);
            check_eq("incp_count", incps, mon_e.incps);
            if (mon_e.chk_pa) begin
              check_eq("quotient_p", p_q, mon_e.q);
              check_eq("remainder_a", a_q, mon_e.r);
            end
          end
        end
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check_eq("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // One request: dividend with start in cycle 0, divisor in cycle 1.
  task automatic run_div(input int unsigned a, input int unsigned b, input bit nolt,
                         input bit poke);
    force_lt0 = nolt;
    @(posedge clk); #1;
    dif.start   = 1'b1;
    dif.data_in = a[W-1:0];
    sb.push_back(model(a, b, nolt));
    @(posedge clk); #1;
    dif.start   = 1'b0;
    dif.data_in = b[W-1:0];
    @(negedge clk);
    check_eq("busy_cycle1", dif.busy, 1);
    check_eq("err_clear_cycle1", dif.err, 0);
    @(posedge clk); #1;
    dif.data_in = W'($urandom);
    if (poke) begin
      // A start raised while busy must be ignored.
      @(posedge clk); #1;
      dif.start   = 1'b1;
      dif.data_in = 5'd1;
      repeat (3) @(posedge clk);
      #1;
      dif.start = 1'b0;
    end
    wait_empty();
  endtask

  bit found;

  initial begin
    rst         = 1'b1;
    force_lt0   = 1'b0;
    dif.start   = 1'b0;
    dif.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctrl", ctrl_vec(), 0);
    rst = 1'b0;

    run_div(13, 4, 1'b0, 1'b0);
    run_div(3, 7, 1'b0, 1'b0);
    run_div(8, 8, 1'b0, 1'b0);
    run_div(9, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("err_hold", dif.err, 1);
    check_eq("idle_after_zero", dif.busy, 0);
    run_div(3, 7, 1'b0, 1'b0);
    run_div(31, 1, 1'b0, 1'b0);
    run_div(31, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_div($urandom_range(31, 0), $urandom_range(31, 1), 1'b0, 1'b0);
    end

    // Reset pulsed during SUB of 20/3.
    force_lt0 = 1'b0;
    @(posedge clk); #1;
    dif.start   = 1'b1;
    dif.data_in = 5'd20;
    sb.push_back(model(20, 3, 1'b0));
    @(posedge clk); #1;
    dif.start   = 1'b0;
    dif.data_in = 5'd3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (dif.incp) found = 1'b1;
    end
    check_eq("sub_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midop_reset_ctrl", ctrl_vec(), 0);
    sb.delete();
    rst = 1'b0;

    run_div(20, 3, 1'b0, 1'b1);

    repeat (10) @(negedge clk);
    check_eq("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
